// File: rtl/branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor : gshare PHT + direct-mapped BTB, trained from EX  (rev 1.0)
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int PHT_BITS = 8,
  parameter int BTB_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         F_PC,
  output logic                F_pred_taken,
  output logic [PHT_BITS-1:0] F_pht_idx,
  output logic                F_btb_hit,
  output logic [31:0]         F_btb_target,
  input  logic                E_valid,
  input  logic                E_is_branch,
  input  logic                E_is_jump,
  input  logic [31:0]         E_PC,
  input  logic                E_taken,
  input  logic [31:0]         E_target,
  input  logic                E_pred_taken,
  input  logic [PHT_BITS-1:0] E_pht_idx,
  input  logic                E_btb_hit,
  input  logic [31:0]         E_btb_target,
  output logic                mispredict,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         br_count,
  output logic [31:0]         mp_count
);

  localparam int PHT_SIZE = 1 << PHT_BITS;
  localparam int BTB_SIZE = 1 << BTB_BITS;
  localparam int TAG_W    = 32 - BTB_BITS - 2;

  logic [1:0]          pht_q        [PHT_SIZE];
  logic [1:0]          pht_d        [PHT_SIZE];
  logic                btb_valid_q  [BTB_SIZE];
  logic                btb_valid_d  [BTB_SIZE];
  logic                btb_jump_q   [BTB_SIZE];
  logic                btb_jump_d   [BTB_SIZE];
  logic [TAG_W-1:0]    btb_tag_q    [BTB_SIZE];
  logic [TAG_W-1:0]    btb_tag_d    [BTB_SIZE];
  logic [31:0]         btb_target_q [BTB_SIZE];
  logic [31:0]         btb_target_d [BTB_SIZE];
  logic [PHT_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         mp_count_q, mp_count_d;

  logic [BTB_BITS-1:0] f_btb_idx, e_btb_idx;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic                is_cond, actual_taken;
  logic                unused_fpc_lsbs;

  assign unused_fpc_lsbs = ^F_PC[1:0];

  assign f_btb_idx    = F_PC[BTB_BITS+1:2];
  assign f_tag        = F_PC[31:BTB_BITS+2];
  assign F_pht_idx    = F_PC[PHT_BITS+1:2] ^ ghr_q;
  assign F_btb_hit    = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign F_btb_target = F_btb_hit ? btb_target_q[f_btb_idx] : 32'd0;
  assign F_pred_taken = F_btb_hit && (btb_jump_q[f_btb_idx] || pht_q[F_pht_idx][1]);

  // Both flags high is resolved as a jump, so a conditional branch excludes it.
  assign is_cond      = E_is_branch & ~E_is_jump;
  assign actual_taken = E_is_jump | (E_is_branch & E_taken);
  assign e_btb_idx    = E_PC[BTB_BITS+1:2];
  assign e_tag        = E_PC[31:BTB_BITS+2];

  assign mispredict  = E_valid && ((actual_taken != E_pred_taken) ||
                       (actual_taken && (!E_btb_hit || (E_btb_target != E_target))));
  assign redirect_pc = !E_valid ? 32'd0 : (actual_taken ? E_target : E_PC + 32'd4);

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

  always_comb begin
    pht_d        = pht_q;
    btb_valid_d  = btb_valid_q;
    btb_jump_d   = btb_jump_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    ghr_d        = ghr_q;
    br_count_d   = br_count_q;
    mp_count_d   = mp_count_q;

    if (E_valid && is_cond) begin
      if (E_taken) begin
        if (pht_q[E_pht_idx] != 2'b11) pht_d[E_pht_idx] = pht_q[E_pht_idx] + 2'd1;
      end else begin
        if (pht_q[E_pht_idx] != 2'b00) pht_d[E_pht_idx] = pht_q[E_pht_idx] - 2'd1;
      end
      ghr_d = {ghr_q[PHT_BITS-2:0], E_taken};
    end

    if (E_valid && actual_taken) begin
      btb_valid_d[e_btb_idx]  = 1'b1;
      btb_jump_d[e_btb_idx]   = E_is_jump;
      btb_tag_d[e_btb_idx]    = e_tag;
      btb_target_d[e_btb_idx] = E_target;
    end

    if (E_valid && (br_count_q != 32'hFFFF_FFFF)) br_count_d = br_count_q + 32'd1;
    if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) mp_count_d = mp_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < BTB_SIZE; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_jump_q[i]   <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= 32'd0;
      end
      ghr_q      <= '0;
      br_count_q <= 32'd0;
      mp_count_q <= 32'd0;
    end else begin
      pht_q        <= pht_d;
      btb_valid_q  <= btb_valid_d;
      btb_jump_q   <= btb_jump_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      ghr_q        <= ghr_d;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predictor : scoreboard bench with a behavioural predictor model
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] F_PC = 32'd0;
  logic        F_pred_taken, F_btb_hit;
  logic [7:0]  F_pht_idx;
  logic [31:0] F_btb_target;
  logic        E_valid = 1'b0, E_is_branch = 1'b0, E_is_jump = 1'b0, E_taken = 1'b0;
  logic [31:0] E_PC = 32'd0, E_target = 32'd0, E_btb_target = 32'd0;
  logic        E_pred_taken = 1'b0, E_btb_hit = 1'b0;
  logic [7:0]  E_pht_idx = 8'd0;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, mp_count;

  branch_predictor #(.PHT_BITS(8), .BTB_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .F_PC(F_PC),
    .F_pred_taken(F_pred_taken), .F_pht_idx(F_pht_idx),
    .F_btb_hit(F_btb_hit), .F_btb_target(F_btb_target),
    .E_valid(E_valid), .E_is_branch(E_is_branch), .E_is_jump(E_is_jump),
    .E_PC(E_PC), .E_taken(E_taken), .E_target(E_target),
    .E_pred_taken(E_pred_taken), .E_pht_idx(E_pht_idx),
    .E_btb_hit(E_btb_hit), .E_btb_target(E_btb_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn, ev, isb, isj, etk, ept, ehit;
    logic [31:0] fpc, epc, etgt, ebt;
    logic [7:0]  eidx;
  } stim_t;

  typedef struct {
    logic        pred, hit, mp;
    logic [7:0]  idx;
    logic [31:0] tgt, rpc, br, mpc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: tables as plain arrays, indexed straight from the PC arithmetic.
  int          m_pht [256];
  bit          m_bv  [64];
  bit          m_bj  [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [7:0]  m_ghr;
  logic [31:0] m_br, m_mp;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 64; i++) begin
      m_bv[i] = 0; m_bj[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_ghr = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void lookup(input logic [31:0] pc, output logic pred,
                                 output logic [7:0] idx, output logic hit,
                                 output logic [31:0] tgt);
    int bi;
    idx = ((pc >> 2) % 256) ^ m_ghr;
    bi  = (pc >> 2) % 64;
    hit = m_bv[bi] && (m_tag[bi] == (pc >> 8));
    tgt = hit ? m_tgt[bi] : 32'd0;
    pred = hit && (m_bj[bi] || (m_pht[idx] >= 2));
  endfunction

  function automatic void train(input stim_t s, input logic act, input logic mp);
    int bi;
    if (!s.rstn) begin
      model_reset();
      return;
    end
    if (!s.ev) return;
    if (s.isb && !s.isj) begin
      if (s.etk) m_pht[s.eidx] = (m_pht[s.eidx] == 3) ? 3 : m_pht[s.eidx] + 1;
      else       m_pht[s.eidx] = (m_pht[s.eidx] == 0) ? 0 : m_pht[s.eidx] - 1;
      m_ghr = (m_ghr * 2 + s.etk) % 256;
    end
    if (act) begin
      bi = (s.epc >> 2) % 64;
      m_bv[bi] = 1; m_bj[bi] = s.isj; m_tag[bi] = s.epc >> 8; m_tgt[bi] = s.etgt;
    end
    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
  endfunction

  function automatic stim_t idle(input logic [31:0] fpc);
    stim_t s;
    s.rstn = 1; s.ev = 0; s.isb = 0; s.isj = 0; s.etk = 0; s.ept = 0; s.ehit = 0;
    s.fpc = fpc; s.epc = 0; s.etgt = 0; s.ebt = 0; s.eidx = 0;
    return s;
  endfunction

  function automatic stim_t br(input logic [31:0] fpc, input logic [31:0] epc,
                               input logic tk, input logic [31:0] tgt, input logic [7:0] idx);
    stim_t s;
    s = idle(fpc);
    s.ev = 1; s.isb = 1; s.epc = epc; s.etk = tk; s.etgt = tgt; s.eidx = idx;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic act;
    @(posedge clk); #1;
    rst_n = s.rstn; F_PC = s.fpc;
    E_valid = s.ev; E_is_branch = s.isb; E_is_jump = s.isj; E_PC = s.epc;
    E_taken = s.etk; E_target = s.etgt; E_pred_taken = s.ept; E_pht_idx = s.eidx;
    E_btb_hit = s.ehit; E_btb_target = s.ebt;
    lookup(s.fpc, e.pred, e.idx, e.hit, e.tgt);
    act   = s.isj | (s.isb & s.etk);
    e.mp  = s.ev && ((act != s.ept) || (act && (!s.ehit || s.ebt != s.etgt)));
    e.rpc = !s.ev ? 32'd0 : (act ? s.etgt : s.epc + 32'd4);
    e.br  = m_br;
    e.mpc = m_mp;
    q.push_back(e);
    train(s, act, e.mp);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("F_pred_taken", {31'd0, F_pred_taken}, {31'd0, me.pred});
      chk("F_pht_idx",    {24'd0, F_pht_idx},    {24'd0, me.idx});
      chk("F_btb_hit",    {31'd0, F_btb_hit},    {31'd0, me.hit});
      chk("F_btb_target", F_btb_target,          me.tgt);
      chk("mispredict",   {31'd0, mispredict},   {31'd0, me.mp});
      chk("redirect_pc",  redirect_pc,           me.rpc);
      chk("br_count",     br_count,              me.br);
      chk("mp_count",     mp_count,              me.mpc);
    end
  end

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return ({30'd0, 2'($urandom_range(0, 3))} << 12) | ({27'd0, 5'($urandom_range(0, 31))} << 2);
  endfunction

  stim_t s;
  initial begin
    model_reset();
    s = idle(32'h100); s.rstn = 0;
    step(s); step(s);
    step(idle(32'h100));                                   // reset defaults, idx 0x40
    step(br(32'h100, 32'h100, 1, 32'h80, 8'h00));          // first taken -> mispredict
    step(idle(32'h100));                                   // BTB hit, idx 0x41, not taken
    step(br(32'h100, 32'h100, 1, 32'h80, 8'h41));
    step(br(32'h100, 32'h100, 1, 32'h80, 8'h41));
    for (int i = 0; i < 8; i++) step(br(32'h100, 32'h3000, 0, 32'h0, 8'h10));
    step(br(32'h100, 32'h104, 1, 32'h10, 8'h11));          // GHR back to 1
    step(idle(32'h100));                                   // idx 0x41 counter 3 -> taken
    for (int i = 0; i < 4; i++) step(br(32'h100, 32'h1000, 1, 32'h40, 8'h05));
    for (int i = 0; i < 4; i++) step(br(32'h100, 32'h1000, 0, 32'h40, 8'h05));
    s = idle(32'h200); s.ev = 1; s.isj = 1; s.epc = 32'h200; s.etgt = 32'h400;
    step(s);                                               // JAL -> mispredict
    step(idle(32'h200));                                   // jump entry predicts taken
    s = br(32'h200, 32'h100, 1, 32'h90, 8'h00);
    s.ept = 1; s.ehit = 1; s.ebt = 32'h80;
    step(s);                                               // wrong target
    s = idle(32'h200); s.ev = 1; s.isb = 1; s.isj = 1; s.epc = 32'h300; s.etgt = 32'h500;
    step(s);                                               // both flags -> jump
    s = br(32'h200, 32'h100, 1, 32'hC0, 8'h22); s.rstn = 0;
    step(s);                                               // reset wins over training
    step(idle(32'h200));
    step(idle(32'h100));

    for (int n = 0; n < 3000; n++) begin
      s = idle(rand_pc());
      s.rstn = ($urandom_range(0, 299) != 0);
      s.ev   = $urandom_range(0, 3) != 0;
      s.isb  = $urandom_range(0, 3) != 0;
      s.isj  = $urandom_range(0, 4) == 0;
      s.epc  = rand_pc();
      s.etk  = 1'($urandom_range(0, 1));
      s.etgt = ($urandom_range(0, 7) == 0) ? 32'h1234 : rand_pc();
      if ($urandom_range(0, 1) == 1) begin
        lookup(s.epc, s.ept, s.eidx, s.ehit, s.ebt);
      end else begin
        s.ept  = 1'($urandom_range(0, 1));
        s.ehit = 1'($urandom_range(0, 1));
        s.eidx = 8'($urandom_range(0, 255));
        s.ebt  = rand_pc();
      end
      step(s);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
